chnlnk_frame_rcvr: RTL

CHNLNK_FRAME_RCVR -- requirements
Module: chnlnk_frame_rcvr

---
 rtl/chnlnk_frame_rcvr_pkg.sv | 35 +++
 rtl/chnlnk_frame_rcvr_crc16_d16.sv | 25 ++
 rtl/chnlnk_frame_rcvr.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/chnlnk_frame_rcvr_pkg.sv
// Shared definitions for the channel-link frame receiver.
// Contents: FSM state encodings, frame layout constants, the CRC-16
// polynomial and preset, and a one-word (16 bits per clock) CRC step.
package chnlnk_frame_rcvr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_DATA    = 3'd2,
    ST_TAIL    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_EVT_END = 3'd5
  } rx_state_e;

  localparam int          FRM_WORDS       = 100;
  localparam logic [6:0]  SEQ_LAST_SAMPLE = 7'd95;
  localparam logic [6:0]  SEQ_CRC         = 7'(FRM_WORDS - 1);

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first CRC over one 16-bit word.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/chnlnk_frame_rcvr_crc16_d16.sv
// CRC-16 accumulator, one 16-bit word per clock.
// Ports: CLK, RST_N (async active-low), INIT (preset, wins over EN),
//        EN (fold D into the running CRC), D[15:0], CRC[15:0] (registered).
module crc16_d16
  import chnlnk_frame_rcvr_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INIT,
  input  logic        EN,
  input  logic [15:0] D,
  output logic [15:0] CRC
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CRC <= CRC_INIT;
    end else if (INIT) begin
      CRC <= CRC_INIT;
    end else if (EN) begin
      CRC <= crc16_next(CRC, D);
    end
  end

endmodule

// File: rtl/chnlnk_frame_rcvr.sv
// Channel-link frame receiver: tracks 100-word frames, forwards the 96
// sample words, checks sequence, gaps and the trailing CRC-16, and
// counts frames per event.
// Ports: CLK, RST_N (async active-low); VALID/DIN/SEQ word input;
//        CLR_CRC pre-frame pulse; LAST_WRD end-of-event pulse;
//        DOUT/WR_EN sample output; FRM_DONE, EVT_DONE pulses;
//        SEQ_ERR/CRC_ERR/GAP_ERR sticky flags; FRM_CNT; RX_STATE debug.
//
// state    | meaning
// IDLE     | waiting for CLR_CRC
// HUNT     | waiting for SEQ 0 of a frame
// DATA     | receiving samples SEQ 1..95
// TAIL     | receiving trailer 96..98 and CRC word 99
// CHECK    | frame complete, FRM_DONE high for this cycle
// EVT_END  | end of event, EVT_DONE high for this cycle
module chnlnk_frame_rcvr
  import chnlnk_frame_rcvr_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID,
  input  logic [15:0] DIN,
  input  logic [6:0]  SEQ,
  input  logic        CLR_CRC,
  input  logic        LAST_WRD,
  output logic [15:0] DOUT,
  output logic        WR_EN,
  output logic        FRM_DONE,
  output logic        EVT_DONE,
  output logic        SEQ_ERR,
  output logic        CRC_ERR,
  output logic        GAP_ERR,
  output logic [7:0]  FRM_CNT,
  output logic [2:0]  RX_STATE
);

  rx_state_e   state, state_nxt;
  logic [1:0]  rst_sync;
  logic        run;
  logic        clr;
  logic [6:0]  exp_seq;
  logic [15:0] crc_val;
  logic        crc_en, crc_init;
  logic        wr_nxt, frm_nxt, set_seq, set_gap, set_crc;

  // Reset release is resynchronised; the FSM stays in IDLE until the
  // second stage has seen it, so no state change on the first edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run      = rst_sync[1];
  assign clr      = run & CLR_CRC;
  assign crc_init = (state_nxt == ST_HUNT);

  crc16_d16 u_crc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INIT  (crc_init),
    .EN    (crc_en),
    .D     (DIN),
    .CRC   (crc_val)
  );

  always_comb begin
    state_nxt = state;
    crc_en    = 1'b0;
    wr_nxt    = 1'b0;
    frm_nxt   = 1'b0;
    set_seq   = 1'b0;
    set_gap   = 1'b0;
    set_crc   = 1'b0;
    if (!run) begin
      state_nxt = ST_IDLE;
    end else if (CLR_CRC) begin
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_HUNT: begin
          if (LAST_WRD) begin
            state_nxt = ST_EVT_END;
          end else if (VALID) begin
            if (SEQ == 7'd0) begin
              state_nxt = ST_DATA;
              crc_en    = 1'b1;
              wr_nxt    = 1'b1;
            end else begin
              set_seq = 1'b1;
            end
          end
        end
        ST_DATA, ST_TAIL: begin
          if (LAST_WRD) begin
            set_gap   = 1'b1;
            state_nxt = ST_EVT_END;
          end else if (!VALID) begin
            set_gap   = 1'b1;
            state_nxt = ST_HUNT;
          end else if (SEQ != exp_seq) begin
            set_seq   = 1'b1;
            state_nxt = ST_HUNT;
          end else if (SEQ == SEQ_CRC) begin
            // crc_val already covers words 0..98 at this point
            frm_nxt   = 1'b1;
            set_crc   = (DIN != crc_val);
            state_nxt = ST_CHECK;
          end else begin
            crc_en = 1'b1;
            wr_nxt = (state == ST_DATA);
            if (SEQ == SEQ_LAST_SAMPLE) state_nxt = ST_TAIL;
          end
        end
        // An end-of-event pulse right behind the last frame lands here.
        ST_CHECK:   state_nxt = LAST_WRD ? ST_EVT_END : ST_HUNT;
        ST_EVT_END: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_seq  <= '0;
      DOUT     <= '0;
      WR_EN    <= 1'b0;
      FRM_DONE <= 1'b0;
      EVT_DONE <= 1'b0;
      SEQ_ERR  <= 1'b0;
      CRC_ERR  <= 1'b0;
      GAP_ERR  <= 1'b0;
      FRM_CNT  <= '0;
    end else begin
      if (state_nxt == ST_HUNT) exp_seq <= '0;
      else if (crc_en)          exp_seq <= exp_seq + 7'd1;

      WR_EN <= wr_nxt;
      if (wr_nxt) DOUT <= DIN;
      FRM_DONE <= frm_nxt;
      EVT_DONE <= (state_nxt == ST_EVT_END);

      if (state == ST_EVT_END)                  FRM_CNT <= '0;
      else if (frm_nxt && FRM_CNT != 8'hFF)     FRM_CNT <= FRM_CNT + 8'd1;

      if (clr) begin
        SEQ_ERR <= 1'b0;
        CRC_ERR <= 1'b0;
        GAP_ERR <= 1'b0;
      end else begin
        if (set_seq) SEQ_ERR <= 1'b1;
        if (set_crc) CRC_ERR <= 1'b1;
        if (set_gap) GAP_ERR <= 1'b1;
      end
    end
  end

  assign RX_STATE = state;

endmodule
